// File: rtl/axil_timeout_guard_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axil_timeout_guard_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid, bready;
  logic [1:0]              bresp;
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid, rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axil_timeout_guard.sv
// AXI4-Lite pass-through that answers SLVERR upstream when the slave stalls,
// then quietly drains the late downstream response.
module axil_timeout_guard #(
  parameter int ADDR_WIDTH     = 40,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADDEAD
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  axil_timeout_guard_if.slave  s_axi,
  axil_timeout_guard_if.master m_axi,
  output logic [CNT_WIDTH-1:0] wr_timeout_cnt,
  output logic [CNT_WIDTH-1:0] rd_timeout_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] W_IDLE = 3'd0, W_ISSUE = 3'd1, W_RESP = 3'd2,
                         W_BUP  = 3'd3, W_TOUT  = 3'd4, W_DRAIN = 3'd5;
  localparam logic [2:0] R_IDLE = 3'd0, R_ISSUE = 3'd1, R_RESP = 3'd2,
                         R_RUP  = 3'd3, R_TOUT  = 3'd4, R_DRAIN = 3'd5;

  // run keeps every upstream ready low until the first clock after reset
  logic run;
  logic [2:0] w_state, r_state;
  logic aw_lat, w_lat, b_seen, ar_lat, r_seen;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [2:0]              awprot_q, arprot_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [TW-1:0]           w_timer, r_timer;

  // ---------------- write path ----------------
  logic w_out, w_busy, w_expire;
  logic aw_hs_up, w_hs_up, aw_hs_dn, w_hs_dn, b_hs, aw_lat_n, w_lat_n;

  assign w_out  = (w_state == W_ISSUE) || (w_state == W_TOUT) || (w_state == W_DRAIN);
  assign w_busy = (w_state == W_ISSUE) || (w_state == W_RESP);

  assign s_axi.awready = run && (w_state == W_IDLE) && !aw_lat;
  assign s_axi.wready  = run && (w_state == W_IDLE) && !w_lat;
  assign s_axi.bvalid  = (w_state == W_BUP) || (w_state == W_TOUT);
  assign s_axi.bresp   = (w_state == W_TOUT) ? 2'b10 : (w_state == W_BUP) ? bresp_q : 2'b00;
  assign m_axi.awvalid = w_out && aw_lat;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = awprot_q;
  assign m_axi.wvalid  = w_out && w_lat;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = (w_state == W_RESP) || ((w_state == W_DRAIN) && !b_seen);

  assign aw_hs_up = s_axi.awvalid && s_axi.awready;
  assign w_hs_up  = s_axi.wvalid  && s_axi.wready;
  assign aw_hs_dn = m_axi.awvalid && m_axi.awready;
  assign w_hs_dn  = m_axi.wvalid  && m_axi.wready;
  assign b_hs     = m_axi.bvalid  && m_axi.bready;
  assign aw_lat_n = (aw_lat || aw_hs_up) && !aw_hs_dn;
  assign w_lat_n  = (w_lat  || w_hs_up)  && !w_hs_dn;
  // a response landing on the expiry cycle beats the timeout
  assign w_expire = w_busy && (w_timer == T_LAST) && !b_hs;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run            <= 1'b0;
      w_state        <= W_IDLE;
      aw_lat         <= 1'b0;
      w_lat          <= 1'b0;
      b_seen         <= 1'b0;
      awaddr_q       <= '0;
      awprot_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      bresp_q        <= '0;
      w_timer        <= '0;
      wr_timeout_cnt <= '0;
    end else begin
      run    <= 1'b1;
      aw_lat <= aw_lat_n;
      w_lat  <= w_lat_n;
      if (aw_hs_up) begin
        awaddr_q <= s_axi.awaddr;
        awprot_q <= s_axi.awprot;
      end
      if (w_hs_up) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (w_busy) w_timer <= w_timer + 1'b1;
      if (w_expire && (wr_timeout_cnt != '1)) wr_timeout_cnt <= wr_timeout_cnt + 1'b1;
      case (w_state)
        W_IDLE:  if (aw_lat_n && w_lat_n) begin
                   w_state <= W_ISSUE;
                   w_timer <= '0;
                 end
        W_ISSUE: if (w_expire) w_state <= W_TOUT;
                 else if (!aw_lat_n && !w_lat_n) w_state <= W_RESP;
        W_RESP:  if (b_hs) begin
                   bresp_q <= m_axi.bresp;
                   w_state <= W_BUP;
                 end else if (w_expire) w_state <= W_TOUT;
        W_BUP:   if (s_axi.bready) w_state <= W_IDLE;
        W_TOUT:  if (s_axi.bready) w_state <= W_DRAIN;
        W_DRAIN: begin
          if (b_hs) b_seen <= 1'b1;
          if ((b_seen || b_hs) && !aw_lat_n && !w_lat_n) begin
            b_seen  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  logic r_out, r_busy, r_expire, ar_hs_up, ar_hs_dn, r_hs, ar_lat_n;

  assign r_out  = (r_state == R_ISSUE) || (r_state == R_TOUT) || (r_state == R_DRAIN);
  assign r_busy = (r_state == R_ISSUE) || (r_state == R_RESP);

  assign s_axi.arready = run && (r_state == R_IDLE);
  assign s_axi.rvalid  = (r_state == R_RUP) || (r_state == R_TOUT);
  assign s_axi.rdata   = (r_state == R_TOUT) ? ERR_RDATA : (r_state == R_RUP) ? rdata_q : '0;
  assign s_axi.rresp   = (r_state == R_TOUT) ? 2'b10 : (r_state == R_RUP) ? rresp_q : 2'b00;
  assign m_axi.arvalid = r_out && ar_lat;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = arprot_q;
  assign m_axi.rready  = (r_state == R_RESP) || ((r_state == R_DRAIN) && !r_seen);

  assign ar_hs_up = s_axi.arvalid && s_axi.arready;
  assign ar_hs_dn = m_axi.arvalid && m_axi.arready;
  assign r_hs     = m_axi.rvalid  && m_axi.rready;
  assign ar_lat_n = (ar_lat || ar_hs_up) && !ar_hs_dn;
  assign r_expire = r_busy && (r_timer == T_LAST) && !r_hs;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state        <= R_IDLE;
      ar_lat         <= 1'b0;
      r_seen         <= 1'b0;
      araddr_q       <= '0;
      arprot_q       <= '0;
      rdata_q        <= '0;
      rresp_q        <= '0;
      r_timer        <= '0;
      rd_timeout_cnt <= '0;
    end else begin
      ar_lat <= ar_lat_n;
      if (ar_hs_up) begin
        araddr_q <= s_axi.araddr;
        arprot_q <= s_axi.arprot;
      end
      if (r_busy) r_timer <= r_timer + 1'b1;
      if (r_expire && (rd_timeout_cnt != '1)) rd_timeout_cnt <= rd_timeout_cnt + 1'b1;
      case (r_state)
        R_IDLE:  if (ar_hs_up) begin
                   r_state <= R_ISSUE;
                   r_timer <= '0;
                 end
        R_ISSUE: if (r_expire) r_state <= R_TOUT;
                 else if (!ar_lat_n) r_state <= R_RESP;
        R_RESP:  if (r_hs) begin
                   rdata_q <= m_axi.rdata;
                   rresp_q <= m_axi.rresp;
                   r_state <= R_RUP;
                 end else if (r_expire) r_state <= R_TOUT;
        R_RUP:   if (s_axi.rready) r_state <= R_IDLE;
        R_TOUT:  if (s_axi.rready) r_state <= R_DRAIN;
        R_DRAIN: begin
          if (r_hs) r_seen <= 1'b1;
          if ((r_seen || r_hs) && !ar_lat_n) begin
            r_seen  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_timeout_guard.sv
// Directed bench for axil_timeout_guard with a short timeout; the slave side is driven by hand.
module tb_axil_timeout_guard;
  localparam int AW = 40, DW = 32, TO = 16, CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] wr_cnt, rd_cnt;

  axil_timeout_guard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up ();
  axil_timeout_guard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();

  axil_timeout_guard #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW),
    .ERR_RDATA(32'hDEADDEAD)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .s_axi(up), .m_axi(dn),
    .wr_timeout_cnt(wr_cnt), .rd_timeout_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic nx;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    up.awvalid = 0; up.awaddr = '0; up.awprot = '0;
    up.wvalid = 0; up.wdata = '0; up.wstrb = '0; up.bready = 0;
    up.arvalid = 0; up.araddr = '0; up.arprot = '0; up.rready = 0;
    dn.awready = 0; dn.wready = 0; dn.bvalid = 0; dn.bresp = '0;
    dn.arready = 0; dn.rvalid = 0; dn.rdata = '0; dn.rresp = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    nx(); nx();
    checks++; if ({up.awready, up.wready, up.bvalid, up.arready, up.rvalid, dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready} !== 10'b0) begin errors++; $display("FAIL rst_handshake got %b exp 0", {up.awready, up.wready, up.bvalid, up.arready, up.rvalid, dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready}); end
    checks++; if ({up.bresp, up.rresp, up.rdata, dn.awaddr} !== 76'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {up.bresp, up.rresp, up.rdata, dn.awaddr}); end
    checks++; if ({wr_cnt, rd_cnt} !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", {wr_cnt, rd_cnt}); end
    rst_n = 1;
    nx(); nx();
    checks++; if ({up.awready, up.wready, up.arready} !== 3'b111) begin errors++; $display("FAIL rst_release_ready got %b exp 111", {up.awready, up.wready, up.arready}); end
  endtask

  task automatic test_basic_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    up.awvalid = 1; up.awaddr = addr; up.awprot = 3'b010;
    up.wvalid = 1; up.wdata = data; up.wstrb = 4'hF;
    checks++; if ({up.awready, up.wready} !== 2'b11) begin errors++; $display("FAIL bw_up_ready got %b exp 11", {up.awready, up.wready}); end
    nx();
    up.awvalid = 0; up.wvalid = 0;
    checks++; if ({dn.awvalid, dn.wvalid} !== 2'b11) begin errors++; $display("FAIL bw_dn_valid got %b exp 11", {dn.awvalid, dn.wvalid}); end
    checks++; if (dn.awaddr !== addr || dn.awprot !== 3'b010) begin errors++; $display("FAIL bw_dn_addr got %h/%b exp %h/010", dn.awaddr, dn.awprot, addr); end
    checks++; if (dn.wdata !== data || dn.wstrb !== 4'hF) begin errors++; $display("FAIL bw_dn_data got %h/%h exp %h/f", dn.wdata, dn.wstrb, data); end
    dn.awready = 1; dn.wready = 1;
    nx();
    dn.awready = 0; dn.wready = 0;
    checks++; if ({dn.awvalid, dn.wvalid, dn.bready} !== 3'b001) begin errors++; $display("FAIL bw_resp_state got %b exp 001", {dn.awvalid, dn.wvalid, dn.bready}); end
    nx(); nx();
    dn.bvalid = 1; dn.bresp = 2'b00;
    checks++; if (up.bvalid !== 1'b0 || dn.bready !== 1'b1) begin errors++; $display("FAIL bw_pre_b got %b%b exp 01", up.bvalid, dn.bready); end
    nx();
    dn.bvalid = 0;
    checks++; if (up.bvalid !== 1'b1 || up.bresp !== 2'b00) begin errors++; $display("FAIL bw_up_b got %b/%b exp 1/00", up.bvalid, up.bresp); end
    up.bready = 1;
    nx();
    up.bready = 0;
    checks++; if (up.bvalid !== 1'b0 || up.awready !== 1'b1) begin errors++; $display("FAIL bw_done got %b%b exp 01", up.bvalid, up.awready); end
    checks++; if ({wr_cnt, rd_cnt} !== 32'h0) begin errors++; $display("FAIL bw_cnt got %h exp 0", {wr_cnt, rd_cnt}); end
  endtask

  task automatic test_w_before_aw;
    logic bad;
    up.wvalid = 1; up.wdata = 32'h11223344; up.wstrb = 4'h3;
    nx();
    up.wvalid = 0;
    checks++; if ({up.wready, up.awready, dn.wvalid} !== 3'b010) begin errors++; $display("FAIL wa_w_latched got %b exp 010", {up.wready, up.awready, dn.wvalid}); end
    nx();
    up.awvalid = 1; up.awaddr = 40'h40; up.awprot = 3'b000;
    checks++; if ({dn.awvalid, dn.wvalid, up.awready} !== 3'b001) begin errors++; $display("FAIL wa_wait_aw got %b exp 001", {dn.awvalid, dn.wvalid, up.awready}); end
    nx();
    up.awvalid = 0;
    checks++; if ({dn.awvalid, dn.wvalid} !== 2'b11 || dn.wdata !== 32'h11223344 || dn.wstrb !== 4'h3 || dn.awaddr !== 40'h40) begin errors++; $display("FAIL wa_issue got %b %h %h %h", {dn.awvalid, dn.wvalid}, dn.wdata, dn.wstrb, dn.awaddr); end
    dn.awready = 1; dn.wready = 1;
    nx();
    dn.awready = 0; dn.wready = 0; dn.bvalid = 1; dn.bresp = 2'b01;
    nx();
    dn.bvalid = 0;
    up.awvalid = 1; up.wvalid = 1; up.awaddr = 40'h80;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (up.bvalid !== 1'b1 || up.bresp !== 2'b01 || up.awready !== 1'b0 || up.wready !== 1'b0 || dn.awvalid !== 1'b0 || dn.wvalid !== 1'b0) bad = 1;
      nx();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wa_hold_b got bad=%b exp 0", bad); end
    up.awvalid = 0; up.wvalid = 0; up.bready = 1;
    checks++; if (up.bvalid !== 1'b1 || up.bresp !== 2'b01) begin errors++; $display("FAIL wa_b_final got %b/%b exp 1/01", up.bvalid, up.bresp); end
    nx();
    up.bready = 0;
    checks++; if ({up.bvalid, dn.awvalid, dn.wvalid, up.awready} !== 4'b0001) begin errors++; $display("FAIL wa_done got %b exp 0001", {up.bvalid, dn.awvalid, dn.wvalid, up.awready}); end
  endtask

  task automatic test_basic_read(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    up.arvalid = 1; up.araddr = addr; up.arprot = 3'b001;
    checks++; if (up.arready !== 1'b1) begin errors++; $display("FAIL rd_arready got %b exp 1", up.arready); end
    nx();
    up.arvalid = 0;
    checks++; if (dn.arvalid !== 1'b1 || dn.araddr !== addr || dn.arprot !== 3'b001) begin errors++; $display("FAIL rd_dn_ar got %b %h %b exp 1 %h 001", dn.arvalid, dn.araddr, dn.arprot, addr); end
    dn.arready = 1;
    nx();
    dn.arready = 0;
    checks++; if (dn.arvalid !== 1'b0 || dn.rready !== 1'b1) begin errors++; $display("FAIL rd_resp_state got %b%b exp 01", dn.arvalid, dn.rready); end
    dn.rvalid = 1; dn.rdata = data; dn.rresp = 2'b00;
    nx();
    dn.rvalid = 0;
    checks++; if (up.rvalid !== 1'b1 || up.rdata !== data || up.rresp !== 2'b00) begin errors++; $display("FAIL rd_up_r got %b %h %b exp 1 %h 00", up.rvalid, up.rdata, up.rresp, data); end
    up.rready = 1;
    nx();
    up.rready = 0;
    checks++; if (up.rvalid !== 1'b0 || up.arready !== 1'b1) begin errors++; $display("FAIL rd_done got %b%b exp 01", up.rvalid, up.arready); end
  endtask

  task automatic test_rd_timeout;
    logic bad;
    up.arvalid = 1; up.araddr = 40'h100; up.arprot = 3'b000;
    nx();
    up.arvalid = 0; dn.arready = 1;
    nx();
    dn.arready = 0;
    bad = 0;
    for (int i = 2; i <= 16; i++) begin
      if (up.rvalid !== 1'b0) bad = 1;
      nx();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rt_early got bad=%b exp 0", bad); end
    checks++; if (up.rvalid !== 1'b1 || up.rdata !== 32'hDEADDEAD || up.rresp !== 2'b10) begin errors++; $display("FAIL rt_err got %b %h %b exp 1 deaddead 10", up.rvalid, up.rdata, up.rresp); end
    checks++; if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin errors++; $display("FAIL rt_cnt got %0d/%0d exp 1/0", rd_cnt, wr_cnt); end
    up.rready = 1;
    nx();
    up.rready = 0;
    checks++; if ({up.rvalid, dn.rready, up.arready} !== 3'b010) begin errors++; $display("FAIL rt_drain got %b exp 010", {up.rvalid, dn.rready, up.arready}); end
    bad = 0;
    repeat (20) begin
      if (up.arready !== 1'b0 || up.rvalid !== 1'b0) bad = 1;
      nx();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rt_drain_hold got bad=%b exp 0", bad); end
    dn.rvalid = 1; dn.rdata = 32'h0BADF00D; dn.rresp = 2'b00;
    nx();
    dn.rvalid = 0;
    checks++; if ({up.rvalid, up.arready, dn.rready} !== 3'b010) begin errors++; $display("FAIL rt_late_dropped got %b exp 010", {up.rvalid, up.arready, dn.rready}); end
    test_basic_read(40'h200, 32'hCAFEF00D);
    checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL rt_cnt_after got %0d exp 1", rd_cnt); end
  endtask

  task automatic test_expiry_tie;
    up.awvalid = 1; up.awaddr = 40'h300; up.wvalid = 1; up.wdata = 32'h55; up.wstrb = 4'hF;
    nx();
    up.awvalid = 0; up.wvalid = 0; dn.awready = 1; dn.wready = 1;
    nx();
    dn.awready = 0; dn.wready = 0;
    for (int i = 2; i < 16; i++) nx();
    dn.bvalid = 1; dn.bresp = 2'b01;
    checks++; if (dn.bready !== 1'b1 || up.bvalid !== 1'b0) begin errors++; $display("FAIL tie_pre got %b%b exp 10", dn.bready, up.bvalid); end
    nx();
    dn.bvalid = 0;
    checks++; if (up.bvalid !== 1'b1 || up.bresp !== 2'b01) begin errors++; $display("FAIL tie_bresp got %b/%b exp 1/01", up.bvalid, up.bresp); end
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL tie_cnt got %0d exp 0", wr_cnt); end
    up.bready = 1;
    nx();
    up.bready = 0;
    checks++; if (up.bvalid !== 1'b0) begin errors++; $display("FAIL tie_done got %b exp 0", up.bvalid); end
  endtask

  task automatic test_wr_timeout;
    up.awvalid = 1; up.awaddr = 40'h400; up.wvalid = 1; up.wdata = 32'h77; up.wstrb = 4'hF;
    nx();
    up.awvalid = 0; up.wvalid = 0;
    for (int i = 1; i <= 16; i++) nx();
    checks++; if (up.bvalid !== 1'b1 || up.bresp !== 2'b10) begin errors++; $display("FAIL wt_err got %b/%b exp 1/10", up.bvalid, up.bresp); end
    checks++; if (wr_cnt !== 16'd1 || {dn.awvalid, dn.wvalid} !== 2'b11) begin errors++; $display("FAIL wt_cnt_valid got %0d %b exp 1 11", wr_cnt, {dn.awvalid, dn.wvalid}); end
    up.bready = 1;
    nx();
    up.bready = 0;
    checks++; if ({up.bvalid, dn.awvalid, dn.wvalid, up.awready} !== 4'b0110) begin errors++; $display("FAIL wt_drain got %b exp 0110", {up.bvalid, dn.awvalid, dn.wvalid, up.awready}); end
    dn.awready = 1; dn.wready = 1;
    nx();
    dn.awready = 0; dn.wready = 0;
    checks++; if ({dn.awvalid, dn.wvalid, dn.bready, up.awready} !== 4'b0010) begin errors++; $display("FAIL wt_drain_b got %b exp 0010", {dn.awvalid, dn.wvalid, dn.bready, up.awready}); end
    dn.bvalid = 1; dn.bresp = 2'b00;
    nx();
    dn.bvalid = 0;
    checks++; if ({up.bvalid, up.awready} !== 2'b01) begin errors++; $display("FAIL wt_done got %b exp 01", {up.bvalid, up.awready}); end
  endtask

  task automatic test_reset_midflight;
    up.awvalid = 1; up.awaddr = 40'h500; up.wvalid = 1; up.wdata = 32'h99;
    up.arvalid = 1; up.araddr = 40'h504;
    nx();
    up.awvalid = 0; up.wvalid = 0; up.arvalid = 0;
    dn.awready = 1; dn.wready = 1;
    nx();
    dn.awready = 0; dn.wready = 0;
    checks++; if ({dn.bready, dn.arvalid} !== 2'b11) begin errors++; $display("FAIL mf_pre got %b exp 11", {dn.bready, dn.arvalid}); end
    rst_n = 0;
    #1;
    checks++; if ({up.awready, up.wready, up.bvalid, up.arready, up.rvalid, dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready} !== 10'b0) begin errors++; $display("FAIL mf_outputs got %b exp 0", {up.awready, up.wready, up.bvalid, up.arready, up.rvalid, dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready}); end
    checks++; if ({wr_cnt, rd_cnt} !== 32'h0) begin errors++; $display("FAIL mf_cnt got %h exp 0", {wr_cnt, rd_cnt}); end
    nx(); nx();
    rst_n = 1;
    nx(); nx();
    checks++; if ({up.awready, up.arready, dn.arvalid, dn.bready} !== 4'b1100) begin errors++; $display("FAIL mf_idle got %b exp 1100", {up.awready, up.arready, dn.arvalid, dn.bready}); end
    test_basic_write(40'h600, 32'h600D600D);
  endtask

  initial begin
    test_reset();
    test_basic_write(40'h8, 32'hA5A5A5A5);
    test_w_before_aw();
    test_basic_read(40'h0, 32'hDEADBEEF);
    test_rd_timeout();
    test_expiry_tie();
    test_wr_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
